// File: rtl/rs_error_corrector_pkg.sv
// Shared GF(2^8) constants, symbol type and corrector state encoding.
// Field is GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 and alpha = 2.
package rs_pkg;

    localparam int unsigned SYM_W     = 8;
    localparam logic [7:0]  GF_POLY   = 8'h1D;
    localparam logic [7:0]  ALPHA_INV = 8'h8E;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        StLoad    = 2'd0,
        StWaitLoc = 2'd1,
        StEmit    = 2'd2
    } state_t;

    // Elaboration-time alpha^e, used only to seed the position register.
    function automatic sym_t gf_alpha_pow(input int unsigned e);
        sym_t x;
        x = 8'h01;
        for (int unsigned i = 0; i < e; i++) begin
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return x;
    endfunction

endpackage

// File: rtl/gf_mul_alpha_inv.sv
// Combinational multiply of a GF(2^8) element by alpha^-1.
module gf_mul_alpha_inv
    import rs_pkg::*;
(
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);

    // Dividing by alpha: shift right, folding the reduced polynomial back in when bit 0 is set.
    assign y = {1'b0, a[SYM_W-1:1]} ^ (a[0] ? ALPHA_INV : 8'h00);

endmodule

// File: rtl/rs_error_corrector.sv
// Reed-Solomon error corrector: buffers a codeword, latches locators/magnitudes,
// then streams the codeword out with matching symbols XOR-corrected.
module rs_error_corrector
    import rs_pkg::*;
#(
    parameter int unsigned N_SYM = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    output logic             in_ready,
    input  logic             loc_valid,
    input  logic [SYM_W-1:0] z1,
    input  logic [SYM_W-1:0] z2,
    input  logic [SYM_W-1:0] z3,
    input  logic [SYM_W-1:0] y1,
    input  logic [SYM_W-1:0] y2,
    input  logic [SYM_W-1:0] y3,
    input  logic             loc_fail,
    output logic             loc_ready,
    output logic             out_valid,
    output logic [SYM_W-1:0] out_data,
    output logic             out_last,
    output logic             out_fail,
    input  logic             out_ready
);

    localparam logic [7:0] LAST   = 8'(N_SYM - 1);
    localparam sym_t       P_INIT = gf_alpha_pow(N_SYM - 1);

    logic [1:0] rst_sync;
    logic       rst_int_n;

    state_t     state;
    logic [7:0] wr_idx;
    logic [7:0] rd_idx;
    logic [7:0] rd_next;
    sym_t       p_q;
    sym_t       p_next;
    sym_t       z1_q, z2_q, z3_q;
    sym_t       y1_q, y2_q, y3_q;
    logic       fail_q;

    logic       in_ready_q;
    logic       loc_ready_q;
    logic       out_valid_q;
    sym_t       out_data_q;
    logic       out_last_q;
    logic       out_fail_q;
    logic       wr_en;

    sym_t       buffer [N_SYM];

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    gf_mul_alpha_inv u_mul (
        .a (p_q),
        .y (p_next)
    );

    // Sum of magnitudes whose locator equals position p; zero locators never match.
    function automatic sym_t correction(input sym_t p);
        sym_t c;
        c = '0;
        if (!fail_q) begin
            if ((z1_q != 8'h00) && (z1_q == p)) c = c ^ y1_q;
            if ((z2_q != 8'h00) && (z2_q == p)) c = c ^ y2_q;
            if ((z3_q != 8'h00) && (z3_q == p)) c = c ^ y3_q;
        end
        return c;
    endfunction

    assign wr_en   = (state == StLoad) && in_valid && in_ready_q;
    assign rd_next = rd_idx + 8'd1;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state       <= StLoad;
            wr_idx      <= '0;
            rd_idx      <= '0;
            p_q         <= '0;
            z1_q        <= '0;
            z2_q        <= '0;
            z3_q        <= '0;
            y1_q        <= '0;
            y2_q        <= '0;
            y3_q        <= '0;
            fail_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            loc_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_fail_q  <= 1'b0;
        end else begin
            unique case (state)
                StLoad: begin
                    in_ready_q <= 1'b1;
                    if (wr_en) begin
                        if (wr_idx == LAST) begin
                            state       <= StWaitLoc;
                            in_ready_q  <= 1'b0;
                            loc_ready_q <= 1'b1;
                        end else begin
                            wr_idx <= wr_idx + 8'd1;
                        end
                    end
                end
                StWaitLoc: begin
                    if (loc_valid) begin
                        z1_q        <= z1;
                        z2_q        <= z2;
                        z3_q        <= z3;
                        y1_q        <= y1;
                        y2_q        <= y2;
                        y3_q        <= y3;
                        fail_q      <= loc_fail;
                        loc_ready_q <= 1'b0;
                        rd_idx      <= '0;
                        p_q         <= P_INIT;
                        state       <= StEmit;
                    end
                end
                StEmit: begin
                    // rd_idx and p_q always describe the symbol held in the output register.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= buffer[rd_idx] ^ correction(p_q);
                        out_last_q  <= (rd_idx == LAST);
                        out_fail_q  <= fail_q;
                    end else if (out_ready) begin
                        if (rd_idx == LAST) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_fail_q  <= 1'b0;
                            rd_idx      <= '0;
                            wr_idx      <= '0;
                            in_ready_q  <= 1'b1;
                            state       <= StLoad;
                        end else begin
                            rd_idx     <= rd_next;
                            p_q        <= p_next;
                            out_data_q <= buffer[rd_next] ^ correction(p_next);
                            out_last_q <= (rd_next == LAST);
                        end
                    end
                end
                default: begin
                    state <= StLoad;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign loc_ready = loc_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_fail  = out_fail_q;

endmodule

// File: tb/tb_rs_error_corrector.sv
// Randomised scoreboard bench for rs_error_corrector against a GF(2^8) exponent-table model.
module tb_rs_error_corrector;

    localparam int N = 255;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       loc_valid = 1'b0;
    logic [7:0] z1 = 8'h00, z2 = 8'h00, z3 = 8'h00;
    logic [7:0] y1 = 8'h00, y2 = 8'h00, y3 = 8'h00;
    logic       loc_fail = 1'b0;
    logic       loc_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_fail;
    logic       out_ready = 1'b0;

    always #5 clk = ~clk;

    rs_error_corrector #(.N_SYM(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .loc_valid (loc_valid),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .loc_fail  (loc_fail),
        .loc_ready (loc_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_fail  (out_fail),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       fail;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         popped = 0;
    int         ready_mode = 0;
    int         pat = 0;
    logic [7:0] alpha_pow [256];
    logic [7:0] cw [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Schoolbook polynomial multiply then reduce by 0x11D.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int k = 15; k >= 8; k--) if (acc[k]) acc = acc ^ (16'h011D << (k - 8));
        return acc[7:0];
    endfunction

    // Monitor: compare every transfer, and check held values across stalls.
    exp_t held;
    logic held_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (held_v) check("stall_hold", {22'd0, out_data, out_last, out_fail}, {22'd0, held});
            if (out_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got %0h expected none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                    check("out_fail", {31'd0, out_fail}, {31'd0, e.fail});
                    popped++;
                end
                held_v = 1'b0;
            end else begin
                held   = {out_data, out_last, out_fail};
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                pat++;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    function automatic logic sig(input int which);
        case (which)
            0: return in_ready;
            1: return loc_ready;
            2: return out_valid;
            default: return (sb.size() == 0);
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int budget);
        int n = 0;
        while (!sig(which) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (!sig(which)) begin
            miscompares++;
            $display("FAIL %s: timed out after %0d cycles, got 0 expected 1", name, budget);
        end
    endtask

    // Load a random codeword, push its expected output, then hand over locators.
    task automatic load_and_locate(input logic [7:0] a1, input logic [7:0] a2,
                                   input logic [7:0] a3, input logic [7:0] b1,
                                   input logic [7:0] b2, input logic [7:0] b3,
                                   input logic fl, input bit gaps);
        logic [7:0] zz [3];
        logic [7:0] yy [3];
        logic [7:0] d;
        logic [7:0] pos;
        logic       acc;
        int         lat;
        zz[0] = a1; zz[1] = a2; zz[2] = a3;
        yy[0] = b1; yy[1] = b2; yy[2] = b3;
        for (int i = 0; i < N; i++) cw[i] = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            pos = alpha_pow[N - 1 - i];
            d   = cw[i];
            if (!fl) for (int k = 0; k < 3; k++) if (zz[k] != 8'h00 && zz[k] == pos) d = d ^ yy[k];
            sb.push_back({d, (i == N - 1), fl});
        end
        wait_for("in_ready_before_load", 0, 20);
        for (int i = 0; i < N; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = cw[i];
            // Stray locator strobe during LOAD must be ignored.
            if (i == 3) begin
                loc_valid = 1'b1;
                z1 = 8'h01; y1 = 8'hFF; loc_fail = 1'b1;
            end
            acc = 1'b0;
            for (int n = 0; n < 20 && !acc; n++) begin
                acc = in_ready;
                @(posedge clk);
                #1;
                loc_valid = 1'b0;
            end
            if (!acc) check("in_accept", 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        wait_for("loc_ready", 1, 10);
        z1 = a1; z2 = a2; z3 = a3; y1 = b1; y2 = b2; y3 = b3; loc_fail = fl;
        loc_valid = 1'b1;
        pat = 0;
        @(posedge clk);
        #1;
        loc_valid = 1'b0;
        z1 = 8'($urandom); z2 = 8'($urandom); z3 = 8'($urandom);
        y1 = 8'($urandom); y2 = 8'($urandom); y3 = 8'($urandom);
        loc_fail = 1'b0;
        lat = 1;
        while (!out_valid && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("loc_to_out_latency_le2", 32'(lat <= 2), 32'd1);
    endtask

    task automatic run_codeword(input logic [7:0] a1, input logic [7:0] a2,
                                input logic [7:0] a3, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic fl, input int mode, input bit gaps);
        ready_mode = mode;
        load_and_locate(a1, a2, a3, b1, b2, b3, fl, gaps);
        wait_for("scoreboard_drain", 3, N * 6 + 20);
        @(posedge clk);
        #1;
        check("out_valid_after_last", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_last", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] r;
        int         p0;
        alpha_pow[0] = 8'h01;
        for (int k = 1; k < 256; k++) alpha_pow[k] = gf_mul(alpha_pow[k - 1], 8'h02);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_loc_ready", {31'd0, loc_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_fail", {31'd0, out_fail}, 32'd0);
        rst_n = 1'b1;
        wait_for("in_ready_after_reset", 0, 10);

        run_codeword(8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 1'b0, 0, 1'b0);
        run_codeword(8'h8E, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        run_codeword(8'h01, 8'h02, 8'h8E, 8'hA1, 8'h3C, 8'hFF, 1'b0, 0, 1'b0);
        run_codeword(8'h8E, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0, 1, 1'b0);
        run_codeword(8'h8E, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 1'b1, 0, 1'b0);
        r = alpha_pow[$urandom_range(0, N - 1)];
        run_codeword(r, r, alpha_pow[$urandom_range(0, N - 1)],
                     8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2, 1'b1);
        run_codeword(alpha_pow[$urandom_range(0, N - 1)], alpha_pow[$urandom_range(0, N - 1)],
                     8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 2, 1'b1);

        // Reset at symbol 100 of EMIT discards the codeword.
        ready_mode = 0;
        p0 = popped;
        load_and_locate(8'h02, 8'h00, 8'h00, 8'h77, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int n = 0; n < 400 && popped < p0 + 100; n++) begin
            @(posedge clk);
            #1;
        end
        check("reached_symbol_100", 32'(popped - p0), 32'd100);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_loc_ready", {31'd0, loc_ready}, 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for("in_ready_after_midrst", 0, 10);
        run_codeword(8'h01, 8'h02, 8'h8E, 8'hA1, 8'h3C, 8'hFF, 1'b0, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rs_error_corrector.md
RS_ERROR_CORRECTOR -- requirements
Module: rs_error_corrector

Interface
REQ-001 Parameter N_SYM, default 255, meaning symbols per codeword (7..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  received-symbol valid.
REQ-005 in_data  input  8  received codeword symbol; highest-degree symbol first.
REQ-006 in_ready  output  1  corrector accepts a symbol this cycle.
REQ-007 loc_valid  input  1  single-cycle strobe; z1..z3, y1..y3, loc_fail valid.
REQ-008 z1, z2, z3  input  8 each  error locators alpha^pos; 8'h00 means slot unused.
REQ-009 y1, y2, y3  input  8 each  error magnitudes paired with z1..z3.
REQ-010 loc_fail  input  1  decoder declares codeword uncorrectable.
REQ-011 loc_ready  output  1  corrector waiting for locator/magnitude set.
REQ-012 out_valid  output  1  corrected symbol valid.
REQ-013 out_data  output  8  corrected symbol, same order as input.
REQ-014 out_last  output  1  marks final symbol of the codeword.
REQ-015 out_fail  output  1  held for the whole codeword when the latched loc_fail was 1.
REQ-016 out_ready  input  1  downstream accepts out_data.

Function
REQ-017 FSM states LOAD, WAIT_LOC, EMIT; reset state LOAD.
REQ-018 LOAD: in_ready=1; each in_valid&in_ready writes in_data to buffer[wr_idx]; wr_idx increments; after N_SYM-th accept -> WAIT_LOC.
REQ-019 WAIT_LOC: in_ready=0, loc_ready=1; on loc_valid latch z1..z3, y1..y3, loc_fail -> EMIT next cycle.
REQ-020 loc_valid outside WAIT_LOC shall be ignored.
REQ-021 EMIT: out_valid=1 while rd_idx<N_SYM; a transfer occurs on out_valid&out_ready; rd_idx increments per transfer only.
REQ-022 out_data, out_last, out_fail shall stay stable while out_valid=1 and out_ready=0.
REQ-023 Symbol index i (0 = first received) has position value p_i = alpha^(N_SYM-1-i) in GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D).
REQ-024 p shall be kept in a register: loaded with alpha^(N_SYM-1) on EMIT entry, multiplied by alpha^-1 (8'h8E) on each transfer; no table lookup.
REQ-025 out_data = buffer[rd_idx] XOR (y1 if z1==p) XOR (y2 if z2==p) XOR (y3 if z3==p); zero z slots never match.
REQ-026 If latched loc_fail=1, out_data = buffer[rd_idx] unmodified and out_fail=1.
REQ-027 Locators equal to each other shall both apply (XOR of both magnitudes); no error flagged.
REQ-028 out_last=1 exactly when rd_idx==N_SYM-1 and out_valid=1.
REQ-029 After the out_last transfer: out_valid=0, rd_idx=wr_idx=0 -> LOAD next cycle.
REQ-030 Buffer read path registered; first out_valid no later than 2 cycles after loc_valid; thereafter 1 symbol/cycle under continuous out_ready.
REQ-031 Counters width 8 bits; no wrap beyond N_SYM-1.

Reset
REQ-032 rst_n low shall immediately force: state LOAD, in_ready=0 during reset then 1 after release, loc_ready=0, out_valid=0, out_last=0, out_fail=0, out_data=8'h00, counters 0, latched z/y/fail 0.
REQ-033 Reset mid-LOAD or mid-EMIT discards the codeword; buffer contents need not be cleared.
REQ-034 rst_n release is synchronised inside the block (assert async, deassert on clk).

Structure
REQ-035 Shared package rs_pkg holds GF_POLY=8'h1D, ALPHA_INV=8'h8E, symbol width 8, state enum.
REQ-036 One sub-module: gf_mul_alpha_inv (combinational constant multiply by alpha^-1); buffer inferred as 255x8 RAM inside the top.

Verification
REQ-037 N_SYM=255, random codeword, z1=z2=z3=0, loc_fail=0 -> output equals input bit-exact, out_last on symbol 254.
REQ-038 Single error at index 0: z1=8'h8E, y1=8'h55, z2=z3=0 -> out[0]=in[0]^8'h55, all others unchanged.
REQ-039 Three errors: z1=8'h01 (index 254), z2=8'h02 (index 253), z3=8'h8E (index 0), y=8'hA1/8'h3C/8'hFF -> exactly those three symbols XORed.
REQ-040 Same as REQ-038 with out_ready toggled 1-0-0-1 pattern -> identical output sequence, outputs stable while stalled.
REQ-041 loc_fail=1 with z1=8'h8E, y1=8'h55 -> output equals input, out_fail=1 on all 255 symbols.
REQ-042 rst_n pulsed low at symbol 100 of EMIT -> out_valid=0 immediately, in_ready=1 after release, next codeword corrects correctly.
